// File: rtl/logo_motion.sv
// Bouncing-logo position generator: moves the logo diagonally once per FRAME_DIV frames at the last pixel.
// Optional LOGO_MOTION_BOUNCE_CNT_EN adds an 8-bit bounce counter output.
module logo_motion #(
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int LOGO_W    = 80,
  parameter int LOGO_H    = 96,
  parameter int STEP_X    = 2,
  parameter int STEP_Y    = 1,
  parameter int FRAME_DIV = 1,
  parameter int X_INIT    = 0,
  parameter int Y_INIT    = 0
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [9:0] x_px,
  input  logic [9:0] y_px,
  input  logic       hold,
  output logic [9:0] x_logo,
  output logic [9:0] y_logo,
  output logic       moving_x,
  output logic       moving_y
`ifdef LOGO_MOTION_BOUNCE_CNT_EN
  ,
  output logic [7:0] bounce_cnt
`endif
);

  localparam logic [9:0] X_LIM    = 10'(SCREEN_W - LOGO_W);
  localparam logic [9:0] Y_LIM    = 10'(SCREEN_H - LOGO_H);
  localparam logic [9:0] X_LAST   = 10'(SCREEN_W - 1);
  localparam logic [9:0] Y_LAST   = 10'(SCREEN_H - 1);
  localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

  logic        frame_end;
  logic        fe_q;
  logic        tick;
  logic        update;
  logic [7:0]  div_cnt;
  logic [10:0] x_sum;
  logic [10:0] y_sum;
  logic [9:0]  x_next;
  logic [9:0]  y_next;
  logic        flip_x;
  logic        flip_y;

  assign frame_end = (x_px == X_LAST) && (y_px == Y_LAST);
  // Rising edge only, so a sync generator parked on the last pixel yields one tick.
  assign tick      = frame_end & ~fe_q;
  assign update    = tick & ~hold & (div_cnt == DIV_LAST);

  // Sums are 11-bit so a step past the right/bottom limit cannot wrap.
  always_comb begin
    x_sum  = {1'b0, x_logo} + 11'(STEP_X);
    x_next = x_logo;
    flip_x = 1'b0;
    if (moving_x) begin
      if (x_sum >= {1'b0, X_LIM}) begin
        x_next = X_LIM;
        flip_x = 1'b1;
      end else begin
        x_next = x_sum[9:0];
      end
    end else if ({1'b0, x_logo} <= 11'(STEP_X)) begin
      x_next = '0;
      flip_x = 1'b1;
    end else begin
      x_next = x_logo - 10'(STEP_X);
    end
  end

  always_comb begin
    y_sum  = {1'b0, y_logo} + 11'(STEP_Y);
    y_next = y_logo;
    flip_y = 1'b0;
    if (moving_y) begin
      if (y_sum >= {1'b0, Y_LIM}) begin
        y_next = Y_LIM;
        flip_y = 1'b1;
      end else begin
        y_next = y_sum[9:0];
      end
    end else if ({1'b0, y_logo} <= 11'(STEP_Y)) begin
      y_next = '0;
      flip_y = 1'b1;
    end else begin
      y_next = y_logo - 10'(STEP_Y);
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      x_logo   <= 10'(X_INIT);
      y_logo   <= 10'(Y_INIT);
      moving_x <= 1'b1;
      moving_y <= 1'b1;
      div_cnt  <= '0;
      fe_q     <= 1'b0;
    end else begin
      fe_q <= frame_end;
      if (tick && !hold) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt  <= '0;
          x_logo   <= x_next;
          y_logo   <= y_next;
          moving_x <= moving_x ^ flip_x;
          moving_y <= moving_y ^ flip_y;
        end else begin
          div_cnt <= div_cnt + 8'd1;
        end
      end
    end
  end

`ifdef LOGO_MOTION_BOUNCE_CNT_EN
  // A corner hit flips both axes but counts as a single bounce.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      bounce_cnt <= '0;
    end else if (update && (flip_x || flip_y)) begin
      bounce_cnt <= bounce_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_logo_motion.sv
// Randomized bench for logo_motion: driver pushes reference-model positions per frame,
// monitor pops them one clk after each frame-end rising edge and checks every cycle.
module tb_logo_motion;
  localparam int SW = 640, SH = 480, LW = 80, LH = 96;
  localparam int SX = 2, SY = 1, FD = 3, XI = 558, YI = 383;
  localparam int XMAX = SW - LW, YMAX = SH - LH;
  localparam int W = 30;
  localparam int NFRAMES = 1700;

  logic       clk = 1'b0;
  logic       clr;
  logic [9:0] x_px, y_px;
  logic       hold;
  logic [9:0] x_logo, y_logo;
  logic       moving_x, moving_y;
  logic [7:0] bc_dut;
  logic [W-1:0] dut_vec;

  logo_motion #(
    .SCREEN_W(SW), .SCREEN_H(SH), .LOGO_W(LW), .LOGO_H(LH),
    .STEP_X(SX), .STEP_Y(SY), .FRAME_DIV(FD), .X_INIT(XI), .Y_INIT(YI)
  ) dut (
    .clk(clk), .clr(clr), .x_px(x_px), .y_px(y_px), .hold(hold),
    .x_logo(x_logo), .y_logo(y_logo), .moving_x(moving_x), .moving_y(moving_y)
`ifdef LOGO_MOTION_BOUNCE_CNT_EN
    , .bounce_cnt(bc_dut)
`endif
  );

`ifndef LOGO_MOTION_BOUNCE_CNT_EN
  assign bc_dut = '0;
`endif
  assign dut_vec = {bc_dut, moving_y, moving_x, y_logo, x_logo};

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // Reference model state: position, direction, frame divider, bounce count.
  int m_x, m_y, m_div, m_bc;
  bit m_mx, m_my;

  function automatic logic [W-1:0] pack_exp();
    logic [7:0] bc;
`ifdef LOGO_MOTION_BOUNCE_CNT_EN
    bc = 8'(m_bc);
`else
    bc = 8'd0;
`endif
    return {bc, m_my, m_mx, 10'(m_y), 10'(m_x)};
  endfunction

  task automatic model_reset();
    m_x = XI; m_y = YI; m_mx = 1; m_my = 1; m_div = 0; m_bc = 0;
  endtask

  task automatic model_frame(input bit h);
    bit bounced;
    if (h) return;
    m_div = m_div + 1;
    if (m_div < FD) return;
    m_div = 0;
    bounced = 0;
    if (m_mx) begin
      if (m_x + SX >= XMAX) begin m_x = XMAX; m_mx = 0; bounced = 1; end
      else m_x = m_x + SX;
    end else begin
      if (m_x <= SX) begin m_x = 0; m_mx = 1; bounced = 1; end
      else m_x = m_x - SX;
    end
    if (m_my) begin
      if (m_y + SY >= YMAX) begin m_y = YMAX; m_my = 0; bounced = 1; end
      else m_y = m_y + SY;
    end else begin
      if (m_y <= SY) begin m_y = 0; m_my = 1; bounced = 1; end
      else m_y = m_y - SY;
    end
    if (bounced) m_bc = (m_bc + 1) % 256;
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got bc=%0d my=%0b mx=%0b y=%0d x=%0d exp bc=%0d my=%0b mx=%0b y=%0d x=%0d",
               name, $time, act[29:22], act[21], act[20], act[19:10], act[9:0],
               exp[29:22], exp[21], exp[20], exp[19:10], exp[9:0]);
    end
  endtask

  // Monitor: detects frame-end rising edges from the stimulus and checks outputs every cycle.
  initial begin
    logic [W-1:0] cur;
    logic [W-1:0] rst_vec;
    bit prev_fe, fe_now, tk;
    rst_vec = {8'd0, 1'b1, 1'b1, 10'(YI), 10'(XI)};
    cur = rst_vec;
    prev_fe = 0;
    forever begin
      @(posedge clk);
      fe_now  = (x_px == 10'(SW - 1)) && (y_px == 10'(SH - 1));
      tk      = fe_now && !prev_fe && !clr;
      prev_fe = clr ? 1'b0 : fe_now;
      @(negedge clk);
      if (clr) begin
        cur = rst_vec;
      end else begin
        if (tk) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL queue_empty t=%0t got no expectation for tick", $time);
          end else begin
            cur = exp_q.pop_front();
          end
        end
        chk(tk ? "update" : "steady", dut_vec, cur);
        checks++;
        if (int'(x_logo) > XMAX || int'(y_logo) > YMAX) begin
          errors++;
          $display("FAIL range t=%0t got x=%0d y=%0d limit x<=%0d y<=%0d", $time, x_logo, y_logo, XMAX, YMAX);
        end
      end
    end
  end

  task automatic set_non_end();
    case ($urandom_range(0, 2))
      0: begin x_px = 10'(SW - 1); y_px = 10'($urandom_range(0, SH - 2)); end
      1: begin x_px = 10'($urandom_range(0, SW - 2)); y_px = 10'(SH - 1); end
      default: begin x_px = 10'($urandom_range(0, SW - 2)); y_px = 10'($urandom_range(0, SH - 2)); end
    endcase
  endtask

  task automatic do_frame(input bit h, input int len);
    int gap;
    model_frame(h);
    exp_q.push_back(pack_exp());
    @(negedge clk);
    hold = h; x_px = 10'(SW - 1); y_px = 10'(SH - 1);
    repeat (len) @(negedge clk);
    gap = $urandom_range(1, 3);
    for (int g = 0; g < gap; g++) begin
      set_non_end();
      hold = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 clr = 1'b1;
    #1 model_reset();
    chk("async_reset", dut_vec, pack_exp());
    @(negedge clk);
    @(negedge clk);
    #1 clr = 1'b0;
  endtask

  initial begin
    bit h;
    clr = 1'b1; x_px = '0; y_px = '0; hold = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 chk("reset", dut_vec, pack_exp());
    @(negedge clk);
    #1 clr = 1'b0;
    for (int f = 0; f < NFRAMES; f++) begin
      if (f == 40 || f == 900) do_reset();
      if (f >= 60 && f < 65) h = 1'b1;
      else h = ($urandom_range(0, 3) == 0);
      do_frame(h, (f % 97 == 0) ? 10 : int'($urandom_range(1, 10)));
    end
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expectations exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
